// File: rtl/up_counter_4bit_synchronous.sv
// Synchronous modulo-(MAX_COUNT+1) up counter.
// All bits update on the same CLK edge. The block has a synchronous clear,
// a clamped parallel load, a count enable, a combinational terminal count,
// a registered one-cycle WRAP pulse and a sticky overflow flag.
// Stages cascade by driving the EN of stage N+1 from the TC of stage N.
module up_counter_4bit_synchronous #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             EN,
    output logic [WIDTH-1:0] COUNT,
    output logic             TC,
    output logic             WRAP,
    output logic             OVF
);

    localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] PRE_MAX_V = WIDTH'(MAX_COUNT - 1);

    typedef enum logic {
        COUNTING,
        TERMINAL
    } state_t;

    state_t state;

    // State, count and flags: CLR beats LOAD, LOAD beats EN, otherwise hold.
    // The state register tracks COUNT == MAX_COUNT so that TC needs no
    // comparator on COUNT. The increment only happens below MAX_COUNT, so
    // COUNT + 1 always fits in WIDTH bits.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= COUNTING;
            COUNT <= '0;
            WRAP  <= 1'b0;
            OVF   <= 1'b0;
        end else if (CLR) begin
            state <= COUNTING;
            COUNT <= '0;
            WRAP  <= 1'b0;
            OVF   <= 1'b0;
        end else if (LOAD) begin
            WRAP <= 1'b0;
            if (LOAD_VAL >= MAX_V) begin
                state <= TERMINAL;
                COUNT <= MAX_V;
            end else begin
                state <= COUNTING;
                COUNT <= LOAD_VAL;
            end
        end else if (EN) begin
            case (state)
                TERMINAL: begin
                    state <= COUNTING;
                    COUNT <= '0;
                    WRAP  <= 1'b1;
                    OVF   <= 1'b1;
                end
                default: begin
                    state <= (COUNT == PRE_MAX_V) ? TERMINAL : COUNTING;
                    COUNT <= COUNT + 1'b1;
                    WRAP  <= 1'b0;
                end
            endcase
        end else begin
            WRAP <= 1'b0;
        end
    end

    // Terminal count is combinational so a cascaded stage advances on the same edge.
    always_comb begin
        TC = (state == TERMINAL) && EN;
    end

endmodule

// File: doc/up_counter_4bit_synchronous.md
# up_counter_4bit_synchronous

Synchronous modulo-N up counter for the counter library, counting in the opposite direction to the existing asynchronous down counter. All bits update on the same `CLK` edge, with no ripple. The block adds synchronous clear, parallel load, count enable, terminal-count and wrap outputs, and a sticky overflow flag. It is intended for cascading and as the up-count source for timers and sequencers.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits; legal range 2..16.
- `MAX_COUNT`, default 15: last value before wrap; must satisfy 1 <= `MAX_COUNT` <= 2^`WIDTH`-1.

Ports:
- `CLK`  input  1  single clock; all state changes on the rising edge.
- `RESET_N`  input  1  reset; asynchronous, active-low.
- `CLR`  input  1  synchronous clear of count and overflow flag.
- `LOAD`  input  1  synchronous parallel load.
- `LOAD_VAL`  input  `WIDTH`  value to load.
- `EN`  input  1  count enable.
- `COUNT`  output  `WIDTH`  current count, registered.
- `TC`  output  1  terminal count, combinational: `COUNT`==`MAX_COUNT` && `EN`.
- `WRAP`  output  1  registered one-cycle pulse, high in the cycle after `COUNT` wraps to 0.
- `OVF`  output  1  sticky flag; set on first wrap, held until `CLR` or reset.

## Operation
- Reset (`RESET_N`=0): `COUNT`=0, `WRAP`=0, `OVF`=0 immediately, independent of `CLK`. `TC`=0 while in reset.
- Priority at each rising edge: `CLR` > `LOAD` > `EN` > hold.
  - `CLR`=1: `COUNT`<=0, `OVF`<=0, `WRAP`<=0.
  - `LOAD`=1, `CLR`=0: `COUNT`<=`LOAD_VAL`. If `LOAD_VAL` > `MAX_COUNT`, `COUNT`<=`MAX_COUNT` (clamp). `WRAP`<=0. `OVF` is unchanged.
  - `EN`=1, `COUNT`<`MAX_COUNT`: `COUNT`<=`COUNT`+1. `WRAP`<=0.
  - `EN`=1, `COUNT`==`MAX_COUNT`: `COUNT`<=0, `WRAP`<=1, `OVF`<=1.
  - Otherwise: `COUNT`, `OVF` hold; `WRAP`<=0.
- Internal states: COUNTING (`COUNT` < `MAX_COUNT`) and TERMINAL (`COUNT`==`MAX_COUNT`).
  - TERMINAL to COUNTING happens only via `EN` wrap, `CLR`, or a `LOAD` below `MAX_COUNT`.
  - COUNTING to TERMINAL happens via increment or via a `LOAD` at or above `MAX_COUNT`.
- Arithmetic: increment is modulo (`MAX_COUNT`+1). `COUNT` never exceeds `MAX_COUNT`. No intermediate width overflow is permitted.
- Cascading: stage N+1 `EN` = stage N `TC`. The chain advances on the same edge, with no extra latency.
- `LOAD` or `CLR` in the same cycle as a would-be wrap suppresses the wrap. `WRAP` stays 0 and `OVF` does not set from that edge.

## Timing
- `COUNT` latency: 1 edge from `EN`/`LOAD`/`CLR` sampled high to the new value.
- `TC`: combinational from the `COUNT` register and `EN`; valid the same cycle.
- `WRAP`: asserted for exactly one cycle following the wrapping edge. Back-to-back wraps (`MAX_COUNT`=1, `EN` held) produce `WRAP` high every other cycle.
- `RESET_N` assertion is asynchronous. Deassertion must meet recovery/removal relative to `CLK`. The first count occurs on the first rising edge with `RESET_N`=1 and `EN`=1.
- Reset mid-count: outputs go to reset values within the same cycle. No partial or ripple states are ever visible on `COUNT`.

## Test plan
- Reset, then `EN`=1 for 17 edges (`MAX_COUNT`=15). Required:
  - `COUNT` runs 0,1,…,15,0,1.
  - `TC`=1 only while `COUNT`=15.
  - `WRAP`=1 in the one cycle after the 15 to 0 edge.
  - `OVF`=1 from then on.
- `LOAD`=1 with `LOAD_VAL`=9, then `EN`=1 for 3 edges: `COUNT`=9,10,11,12. `LOAD_VAL`=14 with `MAX_COUNT`=11: `COUNT`=11 and `TC`=1 (with `EN`=1).
- Priority: at `COUNT`=15 drive `CLR`=`LOAD`=`EN`=1 with `LOAD_VAL`=5. Required: `COUNT`=0, `WRAP`=0, `OVF`=0. Repeat with `CLR`=0: `COUNT`=5, `WRAP`=0, `OVF` unchanged.
- Pull `RESET_N` low mid-cycle at `COUNT`=7 with `EN`=1: `COUNT`=0, `WRAP`=0, `OVF`=0 before the next edge. Release: counts 0,1,2 on subsequent edges.
- Cascade two instances (low `TC` to high `EN`), both `EN` chains active, 256 edges:
  - Combined value steps 0x00 to 0xFF, then 0x00.
  - High-stage `WRAP` pulses exactly once.
  - No cycle shows a mismatched high/low pair.
- `EN`=0 for 5 edges at `COUNT`=3: `COUNT` holds at 3, `TC`=0, `WRAP`=0.
